// File: rtl/filt_addr_sched_if.sv
// filt_addr_sched_if: request/address-stream bundle between accelerators and the scheduler
interface filt_addr_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   offset_bus;
    logic [32*NREQ-1:0]   filesize_bus;
    logic                 pause;
    logic [NREQ-1:0]      grant;
    logic [31:0]          addr;
    logic                 addr_valid;
    logic [NREQ-1:0]      done;
    logic                 busy;

    modport master (
        output req, offset_bus, filesize_bus, pause,
        input  grant, addr, addr_valid, done, busy
    );

    modport slave (
        input  req, offset_bus, filesize_bus, pause,
        output grant, addr, addr_valid, done, busy
    );
endinterface

// File: rtl/filt_addr_sched.sv
// filt_addr_sched: round-robin arbiter that streams sequential word addresses for the winning accelerator
module filt_addr_sched #(
    parameter int NREQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    filt_addr_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [31:0]     size_q, size_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win, idx;
    logic            found;

    // state and datapath registers; reset favours requester 0 on the first arbitration
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    // first requester at or after last_grant+1, wrapping around
    always_comb begin
        win   = last_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_q) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // next state: latch the winner's job in IDLE, step the address in RUN, release in FIN
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = RUN;
                grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win;
                size_d  = bus.filesize_bus[32*int'(win) +: 32];
                addr_d  = bus.offset_bus[32*int'(win) +: 32];
                cnt_d   = '0;
                last_d  = win;
            end
        end else if (state_q == RUN) begin
            if (size_q == '0) begin
                state_d = FIN;
            end else if (!bus.pause) begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == size_q - 32'd1) state_d = FIN;
                else addr_d = addr_q + 32'd1;
            end
        end else begin
            state_d = IDLE;
            grant_d = '0;
        end
    end

    // outputs: addr is registered so it holds outside RUN; valid and done are decoded from state
    always_comb begin
        bus.grant      = grant_q;
        bus.addr       = addr_q;
        bus.addr_valid = (state_q == RUN) && !bus.pause && (size_q != '0);
        bus.done       = (state_q == FIN) ? grant_q : '0;
        bus.busy       = state_q != IDLE;
    end
endmodule
